lsu_ctrl: RTL and testbench

- Load/store unit directly downstream of the ALU stage.
- Takes the ALU's word address (dm_addr), byte offset (remainder) and store data for LOAD/S_TYPE instructions.
- Runs a multi-cycle request/acknowledge transaction with data memory and returns sign/zero-extended load data to writeback.
- Raises a stall to the pipeline while a transaction is in flight.

---
 rtl/lsu_ctrl_if.sv | 41 ++++
 rtl/lsu_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// lsu_ctrl_if : execute-stage, data-memory and writeback signals of lsu_ctrl
// Rev 1.0
// ============================================================================
interface lsu_ctrl_if #(
   parameter int ADDR_W = 14
) ();
   logic              in_valid;
   logic              in_ready;
   logic              is_store;
   logic [2:0]        func3;
   logic [ADDR_W-1:0] dm_addr;
   logic [1:0]        remainder;
   logic [31:0]       st_data;
   logic              stall;
   logic              dm_req;
   logic [3:0]        dm_we;
   logic [ADDR_W-1:0] dm_a;
   logic [31:0]       dm_di;
   logic              dm_ack;
   logic [31:0]       dm_do;
   logic              ld_valid;
   logic [31:0]       ld_data;
   logic              err_valid;
   logic [1:0]        err_cause;

   // master is the surrounding pipeline plus memory; slave is the LSU
   modport master (
      output in_valid, is_store, func3, dm_addr, remainder, st_data, dm_ack, dm_do,
      input  in_ready, stall, dm_req, dm_we, dm_a, dm_di, ld_valid, ld_data,
             err_valid, err_cause
   );

   modport slave (
      input  in_valid, is_store, func3, dm_addr, remainder, st_data, dm_ack, dm_do,
      output in_ready, stall, dm_req, dm_we, dm_a, dm_di, ld_valid, ld_data,
             err_valid, err_cause
   );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// lsu_ctrl : load/store unit, IDLE -> ACCESS -> DONE memory transaction with
//            load extension, ack timeout and optional misalignment trap
//            (macro MISALIGN_TRAP_EN).
// Rev 1.0
// ============================================================================
module lsu_ctrl #(
   parameter int ADDR_W         = 14,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  wire logic clk,
   input  wire logic rst,
   lsu_ctrl_if.slave bus
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam logic [1:0] C_ERR_NONE     = 2'b00;
   localparam logic [1:0] C_ERR_MISALIGN = 2'b01;
   localparam logic [1:0] C_ERR_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_store;
   logic [2:0]        r_func3;
   logic [1:0]        r_rem;
   logic [ADDR_W-1:0] r_a;
   logic [3:0]        r_we;
   logic [31:0]       r_di;
   logic [31:0]       r_ld;
   logic [1:0]        r_err;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_accept;
   logic              w_timeout;
   logic              w_misalign;
   logic [3:0]        w_we;
   logic [31:0]       w_di;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_ld;

   assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_ACCESS) && !bus.dm_ack
                      && (r_cnt == C_CNT_LAST);

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = ((bus.func3[1:0] == 2'b01) && bus.remainder[0]) ||
                       (bus.func3[1] && (bus.remainder != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   // func3[1:0]: 00 byte, 01 half, 1x word (covers the illegal encodings)
   always_comb begin
      w_we = 4'b1111;
      w_di = bus.st_data;
      if (bus.func3[1:0] == 2'b00) begin
         w_we = 4'b0001 << bus.remainder;
         w_di = {4{bus.st_data[7:0]}};
      end else if (bus.func3[1:0] == 2'b01) begin
         w_we = bus.remainder[1] ? 4'b1100 : 4'b0011;
         w_di = {2{bus.st_data[15:0]}};
      end
      if (!bus.is_store) begin
         w_we = 4'b0000;
      end
   end

   always_comb begin
      case (r_rem)
         2'd0:    w_byte = bus.dm_do[7:0];
         2'd1:    w_byte = bus.dm_do[15:8];
         2'd2:    w_byte = bus.dm_do[23:16];
         default: w_byte = bus.dm_do[31:24];
      endcase
      w_half = r_rem[1] ? bus.dm_do[31:16] : bus.dm_do[15:0];
      w_ld   = bus.dm_do;
      if (r_func3[1:0] == 2'b00) begin
         w_ld = {{24{~r_func3[2] & w_byte[7]}}, w_byte};
      end else if (r_func3[1:0] == 2'b01) begin
         w_ld = {{16{~r_func3[2] & w_half[15]}}, w_half};
      end
   end

   always_comb begin
      w_next        = r_state;
      bus.in_ready  = 1'b0;
      bus.stall     = 1'b1;
      bus.dm_req    = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.err_valid = 1'b0;
      bus.err_cause = C_ERR_NONE;
      case (r_state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            bus.stall    = 1'b0;
            if (bus.in_valid) begin
               w_next = w_misalign ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: begin
            bus.dm_req = 1'b1;
            if (bus.dm_ack || w_timeout) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            bus.ld_valid  = !r_store && (r_err == C_ERR_NONE);
            bus.err_valid = (r_err != C_ERR_NONE);
            bus.err_cause = r_err;
            w_next        = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_store <= 1'b0;
         r_func3 <= 3'b000;
         r_rem   <= 2'b00;
         r_a     <= '0;
         r_we    <= 4'b0000;
         r_di    <= 32'h0;
         r_ld    <= 32'h0;
         r_err   <= C_ERR_NONE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_store <= bus.is_store;
            r_func3 <= bus.func3;
            r_rem   <= bus.remainder;
            r_a     <= bus.dm_addr;
            r_we    <= w_we;
            r_di    <= w_di;
            r_err   <= w_misalign ? C_ERR_MISALIGN : C_ERR_NONE;
         end
         // ack has priority over an expiring timeout in the same cycle
         if (r_state == S_ACCESS) begin
            if (bus.dm_ack) begin
               r_cnt <= '0;
               if (!r_store) begin
                  r_ld <= w_ld;
               end
            end else if (w_timeout) begin
               r_cnt <= '0;
               r_err <= C_ERR_TIMEOUT;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.dm_a    = r_a;
   assign bus.dm_we   = r_we;
   assign bus.dm_di   = r_di;
   assign bus.ld_data = r_ld;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// tb_lsu_ctrl : directed self-checking bench for lsu_ctrl
// Rev 1.0
// ============================================================================
module tb_lsu_ctrl;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   req_cycles;
   logic [3:0]  cap_we;
   logic [31:0] cap_di;
   logic [13:0] cap_a;

   lsu_ctrl_if #(.ADDR_W(14)) b ();

   lsu_ctrl #(.ADDR_W(14), .TIMEOUT_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one op, let ACCESS run dly cycles without ack, then ack with rd.
   // Returns sampled in DONE.
   task automatic op(input logic st, input logic [2:0] f3, input logic [13:0] a,
                     input logic [1:0] r, input logic [31:0] sd, input int dly,
                     input logic [31:0] rd);
      b.in_valid  = 1'b1;
      b.is_store  = st;
      b.func3     = f3;
      b.dm_addr   = a;
      b.remainder = r;
      b.st_data   = sd;
      step();
      b.in_valid = 1'b0;
      cap_we     = b.dm_we;
      cap_di     = b.dm_di;
      cap_a      = b.dm_a;
      req_cycles = 0;
      for (int i = 0; i < dly; i++) begin
         if (b.dm_req) req_cycles++;
         step();
      end
      if (b.dm_req) req_cycles++;
      b.dm_ack = 1'b1;
      b.dm_do  = rd;
      step();
      b.dm_ack = 1'b0;
   endtask

   initial begin
      int n;
      total       = 0;
      bad         = 0;
      rst         = 1'b0;
      b.in_valid  = 1'b0;
      b.is_store  = 1'b0;
      b.func3     = 3'b000;
      b.dm_addr   = 14'h0;
      b.remainder = 2'b00;
      b.st_data   = 32'h0;
      b.dm_ack    = 1'b0;
      b.dm_do     = 32'h0;

      #12;
      chk("rst_in_ready", 32'(b.in_ready), 32'd1);
      chk("rst_stall", 32'(b.stall), 32'd0);
      chk("rst_dm_req", 32'(b.dm_req), 32'd0);
      chk("rst_dm_we", 32'(b.dm_we), 32'd0);
      chk("rst_ld_valid", 32'(b.ld_valid), 32'd0);
      chk("rst_err_valid", 32'(b.err_valid), 32'd0);
      rst = 1'b1;
      step();

      // SW, ack in second ACCESS cycle
      op(1'b1, 3'b010, 14'h010, 2'b00, 32'hDEADBEEF, 1, 32'h0);
      chk("sw_req_cycles", 32'(req_cycles), 32'd2);
      chk("sw_we", 32'(cap_we), 32'hF);
      chk("sw_di", cap_di, 32'hDEADBEEF);
      chk("sw_a", 32'(cap_a), 32'h010);
      chk("sw_done_ld_valid", 32'(b.ld_valid), 32'd0);
      chk("sw_done_stall", 32'(b.stall), 32'd1);
      chk("sw_done_in_ready", 32'(b.in_ready), 32'd0);
      chk("sw_done_dm_req", 32'(b.dm_req), 32'd0);
      step();
      chk("sw_idle_in_ready", 32'(b.in_ready), 32'd1);
      chk("sw_idle_stall", 32'(b.stall), 32'd0);

      // SB lane 2
      op(1'b1, 3'b000, 14'h020, 2'b10, 32'h000000A5, 0, 32'h0);
      chk("sb_we", 32'(cap_we), 32'h4);
      chk("sb_di", cap_di, 32'hA5A5A5A5);
      step();

      // SH upper half
      op(1'b1, 3'b001, 14'h021, 2'b10, 32'h1234ABCD, 0, 32'h0);
      chk("sh_we", 32'(cap_we), 32'hC);
      chk("sh_di", cap_di, 32'hABCDABCD);
      step();

      // LB / LBU lane 3
      op(1'b0, 3'b000, 14'h030, 2'b11, 32'h80FFFFFF, 0, 32'h80FFFFFF);
      chk("lb_we", 32'(cap_we), 32'h0);
      chk("lb_valid", 32'(b.ld_valid), 32'd1);
      chk("lb_data", b.ld_data, 32'hFFFFFF80);
      step();
      chk("lb_pulse_end", 32'(b.ld_valid), 32'd0);
      chk("lb_data_hold", b.ld_data, 32'hFFFFFF80);
      op(1'b0, 3'b100, 14'h030, 2'b11, 32'h0, 0, 32'h80FFFFFF);
      chk("lbu_data", b.ld_data, 32'h00000080);
      step();

      // LH / LHU upper half
      op(1'b0, 3'b001, 14'h031, 2'b10, 32'h0, 0, 32'h7FFF1234);
      chk("lh_data", b.ld_data, 32'h00007FFF);
      step();
      op(1'b0, 3'b101, 14'h031, 2'b10, 32'h0, 0, 32'h80015678);
      chk("lhu_data", b.ld_data, 32'h00008001);
      step();
      op(1'b0, 3'b001, 14'h031, 2'b00, 32'h0, 0, 32'h0000F00D);
      chk("lh_low_sign", b.ld_data, 32'hFFFFF00D);
      step();

      // illegal func3 behaves as LW
      op(1'b0, 3'b111, 14'h032, 2'b10, 32'h0, 0, 32'hCAFEF00D);
      chk("illegal_f3_data", b.ld_data, 32'hCAFEF00D);
      step();

      // LW timeout, no ack
      b.in_valid  = 1'b1;
      b.is_store  = 1'b0;
      b.func3     = 3'b010;
      b.dm_addr   = 14'h040;
      b.remainder = 2'b00;
      step();
      b.in_valid = 1'b0;
      n = 0;
      while (b.dm_req && n < 40) begin
         n++;
         step();
      end
      chk("to_req_cycles", 32'(n), 32'd16);
      chk("to_err_valid", 32'(b.err_valid), 32'd1);
      chk("to_err_cause", 32'(b.err_cause), 32'd2);
      chk("to_ld_valid", 32'(b.ld_valid), 32'd0);
      step();
      chk("to_err_pulse_end", 32'(b.err_valid), 32'd0);
      b.dm_ack = 1'b1;
      step();
      b.dm_ack = 1'b0;
      chk("late_ack_in_ready", 32'(b.in_ready), 32'd1);
      chk("late_ack_stall", 32'(b.stall), 32'd0);
      chk("late_ack_ld_valid", 32'(b.ld_valid), 32'd0);
      chk("late_ack_ld_hold", b.ld_data, 32'hCAFEF00D);

      // LW rem=01
`ifdef MISALIGN_TRAP_EN
      b.in_valid  = 1'b1;
      b.is_store  = 1'b0;
      b.func3     = 3'b010;
      b.dm_addr   = 14'h033;
      b.remainder = 2'b01;
      step();
      b.in_valid = 1'b0;
      chk("mis_dm_req", 32'(b.dm_req), 32'd0);
      chk("mis_err_valid", 32'(b.err_valid), 32'd1);
      chk("mis_err_cause", 32'(b.err_cause), 32'd1);
      chk("mis_ld_valid", 32'(b.ld_valid), 32'd0);
      step();
`else
      op(1'b0, 3'b010, 14'h033, 2'b01, 32'h0, 0, 32'h11223344);
      chk("mis_req_cycles", 32'(req_cycles), 32'd1);
      chk("mis_a", 32'(cap_a), 32'h033);
      chk("mis_err_valid", 32'(b.err_valid), 32'd0);
      chk("mis_ld_data", b.ld_data, 32'h11223344);
      step();
`endif

      // reset during ACCESS aborts the op silently
      b.in_valid  = 1'b1;
      b.is_store  = 1'b0;
      b.func3     = 3'b010;
      b.dm_addr   = 14'h050;
      b.remainder = 2'b00;
      step();
      b.in_valid = 1'b0;
      chk("abort_req_before", 32'(b.dm_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_req_drop", 32'(b.dm_req), 32'd0);
      chk("abort_in_ready", 32'(b.in_ready), 32'd1);
      chk("abort_ld_data_clr", b.ld_data, 32'h0);
      #1;
      rst = 1'b1;
      step();
      chk("abort_ld_valid", 32'(b.ld_valid), 32'd0);
      chk("abort_err_valid", 32'(b.err_valid), 32'd0);
      chk("abort_stall", 32'(b.stall), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
